cby_param: RTL and testbench
============================

CBY_PARAM -- requirements
Module: cby_param

Interface
REQ-001 SHALL have parameter CHAN_W, default 9: tracks per direction.
REQ-002 SHALL have parameter NUM_IPIN, default 5: grid input pins driven.
REQ-003 SHALL have parameter MUX_SIZE, default 6, even and >=2: inputs per ipin mux.
REQ-004 SHALL have parameter TAP_STEP, default 4: track stride between mux tap pairs.
REQ-005 SHALL have ports, in this order:
- prog_clk  in  1  configuration clock.
- prog_reset  in  1  reset, asynchronous, active-high.
- cfg_en  in  1  shift enable.
- ccff_head  in  1  serial configuration in.
- cfg_commit  in  1  request to apply the shadow chain to the active selects.
- chany_bottom_in  in  CHAN_W  upward tracks.
- chany_top_in  in  CHAN_W  downward tracks.
- chany_bottom_out  out  CHAN_W  downward pass-through.
- chany_top_out  out  CHAN_W  upward pass-through.
- ipin_out  out  NUM_IPIN  grid pin drives.
- ccff_tail  out  1  serial configuration out.
- cfg_active  out  1  active selects valid.
- cfg_err  out  1  sticky commit error.
REQ-006 SHALL use one clock, prog_clk; prog_reset SHALL be asynchronous and active-high.

Function
REQ-007 Definitions: SEL_W = clog2(MUX_SIZE); CFG_BITS = NUM_IPIN*SEL_W (+1 with parity, see Configuration).
REQ-008 chany_top_out SHALL equal chany_bottom_in, and chany_bottom_out SHALL equal chany_top_in, combinationally.
REQ-009 For ipin i, mux input 2k SHALL be chany_bottom_in[(i+k*TAP_STEP) mod CHAN_W] and input 2k+1 SHALL be chany_top_in at the same index, for k=0..MUX_SIZE/2-1.
REQ-010 ipin_out[i] SHALL be combinational from the active select act_sel[i]; it SHALL be 0 when cfg_active=0 or act_sel[i]>=MUX_SIZE.
REQ-011 On each prog_clk with cfg_en=1, the shadow chain SHALL shift: shadow <= {shadow[CFG_BITS-2:0], ccff_head}; ccff_tail SHALL equal shadow[CFG_BITS-1].
REQ-012 Shadow bits [i*SEL_W +: SEL_W] SHALL be the shadow select for ipin i.
REQ-013 A saturating bit counter SHALL count shifts since the last commit or reset.
REQ-014 FSM states:
- IDLE: count=0.
- SHIFT: 0<count<CFG_BITS.
- READY: count=CFG_BITS.
- OVER: count>CFG_BITS.
- Transitions are driven by shifts; any commit returns the FSM to IDLE.
REQ-015 cfg_commit in READY with cfg_en=0 SHALL copy the shadow selects to act_sel on that edge and set cfg_active=1 next cycle; latency from commit edge to new ipin_out SHALL be 1 cycle.
REQ-016 cfg_commit in IDLE, SHIFT or OVER SHALL leave act_sel and cfg_active unchanged and set cfg_err=1 (sticky until reset).
REQ-017 If cfg_en and cfg_commit are both 1, the shift SHALL occur, the commit SHALL be ignored, and cfg_err SHALL NOT change.
REQ-018 The shadow chain SHALL keep shifting in every state, so reconfiguration while cfg_active=1 never disturbs ipin_out until a valid commit.

Reset
REQ-019 prog_reset SHALL immediately clear the shadow chain, act_sel, counter, cfg_active, cfg_err and ccff_tail, and force the FSM to IDLE; ipin_out SHALL then be 0.
REQ-020 A reset asserted mid-shift or mid-commit SHALL discard the partial load; no partial act_sel update SHALL be visible.

Configuration
REQ-021 With CBY_CFG_PARITY_EN defined, CFG_BITS SHALL include one extra parity bit at shadow[CFG_BITS-1]. A READY commit SHALL apply only if the XOR of all shadow bits is 0; otherwise act_sel is unchanged and cfg_err=1.
REQ-022 Without CBY_CFG_PARITY_EN, there SHALL be no parity bit and no parity check.

Structure
REQ-023 A shared package SHALL hold the FSM state enum, the SEL_W/CFG_BITS computation functions, and the tap-index function.
REQ-024 One sub-module, cby_ipin_mux (MUX_SIZE-input, SEL_W-select, out-of-range gives 0), SHALL be instantiated NUM_IPIN times.

Verification (defaults; no parity unless stated)
REQ-025 Reset release, then drive chany_bottom_in=9'h1FF -> ipin_out=0, cfg_active=0, chany_top_out=9'h1FF.
REQ-026 Shift 15 bits giving all selects =2, commit, bottom_in[4]=1 -> ipin_out[0]=1 one cycle after commit, cfg_active=1.
REQ-027 Commit after 14 shifts -> cfg_err=1, cfg_active stays 0; after 16 shifts then commit -> cfg_err=1.
REQ-028 Active config loaded, shift 15 new bits, no commit -> ipin_out unchanged; ccff_tail shows the old bits in order.
REQ-029 Select value 7 (>=6) for ipin 3, commit -> ipin_out[3]=0 regardless of inputs; cfg_en and cfg_commit high together -> shift only, no cfg_err.
REQ-030 With CBY_CFG_PARITY_EN, 16 bits with odd total parity, commit -> cfg_err=1 and act_sel unchanged; even parity -> applied.

Source files
------------

// File: rtl/cby_param_pkg.sv
// Shared definitions for the Y-direction connection block.
// Optional feature macro: CBY_CFG_PARITY_EN adds one even-parity bit
// to the configuration chain.
package cby_param_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    READY = 2'd2,
    OVER  = 2'd3
  } cfg_state_t;

  // Select width for a mux with mux_size inputs.
  function automatic int sel_width(input int mux_size);
    return (mux_size <= 1) ? 1 : $clog2(mux_size);
  endfunction

  // Length of the configuration chain, including the parity bit when enabled.
  function automatic int cfg_bits(input int num_ipin, input int sel_w);
`ifdef CBY_CFG_PARITY_EN
    return num_ipin * sel_w + 1;
`else
    return num_ipin * sel_w;
`endif
  endfunction

  // Track index tapped by tap pair k of ipin i.
  function automatic int tap_index(input int i, input int k, input int step, input int chan_w);
    return (i + k * step) % chan_w;
  endfunction

endpackage

// File: rtl/cby_ipin_mux.sv
// One grid-input-pin mux: picks din[sel]; select codes past the last
// input drive 0.
module cby_ipin_mux #(
  parameter int MUX_SIZE = 6,
  parameter int SEL_W    = 3
) (
  input  logic [MUX_SIZE-1:0] din,
  input  logic [SEL_W-1:0]    sel,
  output logic                dout
);

  // Compare against every legal code so unused codes fall through to 0.
  always_comb begin
    // NOTE: the default assignment before the loop keeps this block from inferring a latch.
    dout = 1'b0;
    for (int j = 0; j < MUX_SIZE; j++) begin
      if (sel == SEL_W'(j)) dout = din[j];
    end
  end

endmodule

// File: rtl/cby_param.sv
// Parameterised Y connection block: pass-through tracks, NUM_IPIN tapped
// muxes, and a shadow configuration chain applied atomically on commit.
// Optional feature macro: CBY_CFG_PARITY_EN (even parity over the chain).
module cby_param
  import cby_param_pkg::*;
#(
  parameter int CHAN_W   = 9,
  parameter int NUM_IPIN = 5,
  parameter int MUX_SIZE = 6,
  parameter int TAP_STEP = 4
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                cfg_en,
  input  logic                ccff_head,
  input  logic                cfg_commit,
  input  logic [CHAN_W-1:0]   chany_bottom_in,
  input  logic [CHAN_W-1:0]   chany_top_in,
  output logic [CHAN_W-1:0]   chany_bottom_out,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                ccff_tail,
  output logic                cfg_active,
  output logic                cfg_err
);

  localparam int SEL_W    = sel_width(MUX_SIZE);
  localparam int CFG_BITS = cfg_bits(NUM_IPIN, SEL_W);
  localparam int SELS_W   = NUM_IPIN * SEL_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_BITS + 1);

  cfg_state_t                         state, state_nxt;
  logic [CNT_W-1:0]                   count, count_nxt;
  logic [CFG_BITS-1:0]                shadow;
  logic [SELS_W-1:0]                  act_sel;
  logic [NUM_IPIN-1:0][MUX_SIZE-1:0]  mux_in;
  logic [NUM_IPIN-1:0]                mux_out;
  logic                               commit_req;
  logic                               parity_ok;
  logic                               commit_ok;

  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;
  assign ccff_tail        = shadow[CFG_BITS-1];

  // A commit coinciding with a shift is ignored entirely.
  assign commit_req = cfg_commit & ~cfg_en;

`ifdef CBY_CFG_PARITY_EN
  assign parity_ok = ~(^shadow);
`else
  assign parity_ok = 1'b1;
`endif

  assign commit_ok = commit_req && (state == READY) && parity_ok;

  // Next-state and shift-counter logic; the state mirrors the saturating count.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (cfg_en) begin
      count_nxt = (count == CNT_OVER) ? count : count + CNT_W'(1);
      if (count_nxt == '0)            state_nxt = IDLE;
      else if (count_nxt < CNT_FULL)  state_nxt = SHIFT;
      else if (count_nxt == CNT_FULL) state_nxt = READY;
      else                            state_nxt = OVER;
    end else if (commit_req) begin
      count_nxt = '0;
      state_nxt = IDLE;
    end
  end

  // State and counter registers.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Shadow configuration chain, shifting MSB-ward in every state.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      // NOTE: the chain is cleared on reset so ccff_tail is defined immediately afterwards.
      shadow <= '0;
    end else if (cfg_en) begin
      shadow <= {shadow[CFG_BITS-2:0], ccff_head};
    end
  end

  // Active selects, validity flag and sticky commit error.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      act_sel    <= '0;
      cfg_active <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (commit_ok) begin
      act_sel    <= shadow[SELS_W-1:0];
      cfg_active <= 1'b1;
    end else if (commit_req) begin
      cfg_err    <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
    for (genvar k = 0; k < MUX_SIZE / 2; k++) begin : g_tap
      assign mux_in[i][2*k]   = chany_bottom_in[tap_index(i, k, TAP_STEP, CHAN_W)];
      assign mux_in[i][2*k+1] = chany_top_in[tap_index(i, k, TAP_STEP, CHAN_W)];
    end

    cby_ipin_mux #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_mux (
      .din  (mux_in[i]),
      .sel  (act_sel[i*SEL_W +: SEL_W]),
      .dout (mux_out[i])
    );
  end

  assign ipin_out = mux_out & {NUM_IPIN{cfg_active}};

endmodule

// File: tb/tb_cby_param.sv
// Directed bench for cby_param at default parameters. Defining
// CBY_CFG_PARITY_EN also runs the parity scenario.
module tb_cby_param;

`ifdef CBY_CFG_PARITY_EN
  localparam int CFG = 16;
`else
  localparam int CFG = 15;
`endif

  logic       prog_clk = 1'b0;
  logic       prog_reset = 1'b0;
  logic       cfg_en = 1'b0;
  logic       ccff_head = 1'b0;
  logic       cfg_commit = 1'b0;
  logic [8:0] bi = '0;
  logic [8:0] ti = '0;
  logic [8:0] bo, to;
  logic [4:0] ipin;
  logic       tail, active, err;

  int checks = 0;
  int failures = 0;

  cby_param dut (
    .prog_clk         (prog_clk),
    .prog_reset       (prog_reset),
    .cfg_en           (cfg_en),
    .ccff_head        (ccff_head),
    .cfg_commit       (cfg_commit),
    .chany_bottom_in  (bi),
    .chany_top_in     (ti),
    .chany_bottom_out (bo),
    .chany_top_out    (to),
    .ipin_out         (ipin),
    .ccff_tail        (tail),
    .cfg_active       (active),
    .cfg_err          (err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Build a chain word from five 3-bit selects; parity bit on top when enabled.
  function automatic logic [15:0] make_word(input logic [14:0] sels);
`ifdef CBY_CFG_PARITY_EN
    return {^sels, sels};
`else
    return {1'b0, sels};
`endif
  endfunction

  task automatic shift_word(input logic [15:0] w);
    for (int b = CFG - 1; b >= 0; b--) begin
      ccff_head = w[b];
      cfg_en = 1'b1;
      tick();
    end
    cfg_en = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic shift_n(input int n);
    for (int b = 0; b < n; b++) begin
      cfg_en = 1'b1;
      tick();
    end
    cfg_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    prog_reset = 1'b1;
    tick();
    prog_reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    prog_reset = 1'b1;
    #2;
    checks++; if (ipin !== 5'd0) begin failures++; $display("FAIL reset_ipin got=%h exp=%h", ipin, 5'd0); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (tail !== 1'b0) begin failures++; $display("FAIL reset_tail got=%b exp=0", tail); end
    tick();
    prog_reset = 1'b0;
    tick();
    bi = 9'h1FF;
    ti = 9'h0A5;
    #1;
    checks++; if (ipin !== 5'd0) begin failures++; $display("FAIL idle_ipin got=%h exp=%h", ipin, 5'd0); end
    checks++; if (to !== 9'h1FF) begin failures++; $display("FAIL top_out got=%h exp=%h", to, 9'h1FF); end
    checks++; if (bo !== 9'h0A5) begin failures++; $display("FAIL bottom_out got=%h exp=%h", bo, 9'h0A5); end
  endtask

  task automatic test_commit();
    do_reset();
    bi = 9'h010;
    ti = 9'h000;
    shift_word(make_word({5{3'd2}}));
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL precommit_active got=%b exp=0", active); end
    commit();
    checks++; if (ipin !== 5'b00001) begin failures++; $display("FAIL commit_ipin got=%b exp=%b", ipin, 5'b00001); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL commit_active got=%b exp=1", active); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL commit_err got=%b exp=0", err); end
    bi = 9'h1F0;
    ti = 9'h1FF;
    #1;
    checks++; if (ipin !== 5'b11111) begin failures++; $display("FAIL commit_ipin2 got=%b exp=%b", ipin, 5'b11111); end
    bi = 9'h0A0;
    #1;
    checks++; if (ipin !== 5'b01010) begin failures++; $display("FAIL commit_ipin3 got=%b exp=%b", ipin, 5'b01010); end
  endtask

  task automatic test_commit_errors();
    do_reset();
    shift_n(CFG - 1);
    commit();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", err); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL short_active got=%b exp=0", active); end
    do_reset();
    shift_n(CFG + 1);
    commit();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL long_err got=%b exp=1", err); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL long_active got=%b exp=0", active); end
  endtask

  task automatic test_reconfig();
    logic [15:0] old_w;
    logic [15:0] new_w;
    do_reset();
    old_w = make_word({5{3'd2}});
    new_w = make_word({5{3'd1}});
    shift_word(old_w);
    commit();
    bi = 9'h1F0;
    ti = 9'h005;
    #1;
    checks++; if (ipin !== 5'b11111) begin failures++; $display("FAIL reconf_base got=%b exp=%b", ipin, 5'b11111); end
    for (int j = 0; j < CFG; j++) begin
      checks++; if (tail !== old_w[CFG-1-j]) begin failures++; $display("FAIL reconf_tail%0d got=%b exp=%b", j, tail, old_w[CFG-1-j]); end
      ccff_head = new_w[CFG-1-j];
      cfg_en = 1'b1;
      tick();
      cfg_en = 1'b0;
      checks++; if (ipin !== 5'b11111) begin failures++; $display("FAIL reconf_hold%0d got=%b exp=%b", j, ipin, 5'b11111); end
    end
    ccff_head = 1'b0;
    commit();
    checks++; if (ipin !== 5'b00101) begin failures++; $display("FAIL reconf_new got=%b exp=%b", ipin, 5'b00101); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] w;
    do_reset();
    shift_word(make_word(15'h0E00));
    commit();
    bi = 9'h1FF;
    ti = 9'h1FF;
    #1;
    checks++; if (ipin !== 5'b10111) begin failures++; $display("FAIL oor_ipin got=%b exp=%b", ipin, 5'b10111); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_err got=%b exp=0", err); end
    // First bit of the next word is shifted with commit also high.
    w = make_word({5{3'd2}});
    ccff_head = w[CFG-1];
    cfg_en = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_en = 1'b0;
    cfg_commit = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL both_err got=%b exp=0", err); end
    checks++; if (ipin !== 5'b10111) begin failures++; $display("FAIL both_ipin got=%b exp=%b", ipin, 5'b10111); end
    for (int b = CFG - 2; b >= 0; b--) begin
      ccff_head = w[b];
      cfg_en = 1'b1;
      tick();
    end
    cfg_en = 1'b0;
    bi = 9'h1F0;
    ti = 9'h000;
    #1;
    checks++; if (ipin !== 5'b10000) begin failures++; $display("FAIL both_old got=%b exp=%b", ipin, 5'b10000); end
    commit();
    checks++; if (ipin !== 5'b11111) begin failures++; $display("FAIL both_applied got=%b exp=%b", ipin, 5'b11111); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL both_err2 got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    shift_word(make_word({5{3'd2}}));
    commit();
    bi = 9'h1F0;
    shift_n(CFG);
    ccff_head = 1'b1;
    cfg_en = 1'b1;
    tick();
    tick();
    #2;
    prog_reset = 1'b1;
    #1;
    checks++; if (ipin !== 5'd0) begin failures++; $display("FAIL midrst_ipin got=%b exp=%b", ipin, 5'd0); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL midrst_active got=%b exp=0", active); end
    checks++; if (tail !== 1'b0) begin failures++; $display("FAIL midrst_tail got=%b exp=0", tail); end
    cfg_en = 1'b0;
    ccff_head = 1'b0;
    tick();
    prog_reset = 1'b0;
    tick();
    commit();
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL midrst_commit got=%b exp=0", active); end
    checks++; if (ipin !== 5'd0) begin failures++; $display("FAIL midrst_ipin2 got=%b exp=%b", ipin, 5'd0); end
  endtask

`ifdef CBY_CFG_PARITY_EN
  task automatic test_parity();
    logic [14:0] sels;
    do_reset();
    shift_word(make_word(15'd0));
    commit();
    bi = 9'h1F0;
    ti = 9'h000;
    #1;
    checks++; if (ipin !== 5'b10000) begin failures++; $display("FAIL par_base got=%b exp=%b", ipin, 5'b10000); end
    sels = {5{3'd2}};
    shift_word({~(^sels), sels});
    commit();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL par_odd_err got=%b exp=1", err); end
    checks++; if (ipin !== 5'b10000) begin failures++; $display("FAIL par_odd_ipin got=%b exp=%b", ipin, 5'b10000); end
    shift_word({^sels, sels});
    commit();
    checks++; if (ipin !== 5'b11111) begin failures++; $display("FAIL par_even_ipin got=%b exp=%b", ipin, 5'b11111); end
  endtask
`endif

  initial begin
    test_reset();
    test_commit();
    test_commit_errors();
    test_reconfig();
    test_out_of_range();
    test_reset_mid();
`ifdef CBY_CFG_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
